// File: rtl/game_regs_pkg.sv
// Register-file indices and widths shared by blocks that snoop or inject into
// the processor regfile (score injection into r30, mailbox capture).
package game_regs_pkg;

  localparam int REG_IDX_W        = 5;
  localparam int SCORE_REG        = 30;
  localparam int MBOX_REG_DEFAULT = 29;
  localparam int DROP_CNT_W       = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // r0 is hard-wired and r30 belongs to hardware score injection.
  function automatic bit mbox_reg_legal(input int idx);
    return (idx >= 1) && (idx <= 31) && (idx != SCORE_REG);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through from registered storage;
// occupancy is held in a counter and full/empty are decoded from it.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_eff;
  logic             pop_eff;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is accepted only when a pop frees a slot at the same edge.
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_eff) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/regfile_mailbox_reader.sv
// Snoops the processor regfile write port and queues every software write to
// the mailbox register for hardware consumers over a valid/ready interface.
module regfile_mailbox_reader
  import game_regs_pkg::*;
#(
  parameter int MBOX_REG = MBOX_REG_DEFAULT,
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ctrl_writeEnable,
  input  logic [REG_IDX_W-1:0]       ctrl_writeReg,
  input  logic [WIDTH-1:0]           data_writeReg,
  input  logic                       inject_active,
  output logic                       cmd_valid,
  output logic [WIDTH-1:0]           cmd_data,
  input  logic                       cmd_ready,
  output logic [$clog2(DEPTH):0]     cmd_count,
  output logic                       overflow,
  output logic [DROP_CNT_W-1:0]      drop_count,
  input  logic                       clear_overflow
);

  // An illegal mailbox index disables capture rather than snooping r0 or r30.
  localparam bit                   MBOX_OK  = mbox_reg_legal(MBOX_REG);
  localparam logic [REG_IDX_W-1:0] MBOX_IDX = REG_IDX_W'(MBOX_REG);

  logic             cap;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] head;

  assign cap = MBOX_OK && ctrl_writeEnable && (ctrl_writeReg == MBOX_IDX) && !inject_active;

  // Handshake: the head transfers at a rising edge where cmd_valid && cmd_ready;
  // cmd_data is stable while cmd_valid is high and the consumer has not accepted.
  assign pop  = cmd_valid && cmd_ready;
  assign drop = cap && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cap),
    .pop   (pop),
    .wdata (data_writeReg),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (cmd_count)
  );

  assign cmd_valid = !fifo_empty;
  assign cmd_data  = cmd_valid ? head : '0;

  // Clearing takes priority over a drop in the same cycle.
  always_ff @(posedge clock) begin
    if (reset || clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != DROP_CNT_MAX) drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_mailbox_reader.sv
// Directed bench for regfile_mailbox_reader with DEPTH=4, mailbox r29.
module tb_regfile_mailbox_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        inject_active;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic [2:0]  cmd_count;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        clear_overflow;

  int checks = 0;
  int errors = 0;

  always #20 clock = ~clock;

  regfile_mailbox_reader #(.MBOX_REG(29), .DEPTH(4), .WIDTH(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .inject_active    (inject_active),
    .cmd_valid        (cmd_valid),
    .cmd_data         (cmd_data),
    .cmd_ready        (cmd_ready),
    .cmd_count        (cmd_count),
    .overflow         (overflow),
    .drop_count       (drop_count),
    .clear_overflow   (clear_overflow)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'd0;
    inject_active    = 1'b0;
    cmd_ready        = 1'b0;
    clear_overflow   = 1'b0;
  endtask

  // One processor write lasting a single cycle.
  task automatic rf_write(input logic [4:0] r, input logic [31:0] d, input logic inj, input logic rdy);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = r;
    data_writeReg    = d;
    inject_active    = inj;
    cmd_ready        = rdy;
    step();
    idle_inputs();
  endtask

  task automatic pop_one();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_data !== 32'd0 || cmd_count !== 3'd0 ||
        overflow !== 1'b0 || drop_count !== 8'd0) begin
      $display("FAIL reset_values: got valid=%b data=%h count=%0d ovf=%b drops=%0d want all 0",
               cmd_valid, cmd_data, cmd_count, overflow, drop_count);
      errors++;
    end
  endtask

  task automatic test_capture_pop();
    rf_write(5'd29, 32'h0000_0005, 1'b0, 1'b0);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== 32'd5 || cmd_count !== 3'd1) begin
      $display("FAIL capture: got valid=%b data=%h count=%0d want 1/5/1", cmd_valid, cmd_data, cmd_count);
      errors++;
    end
    pop_one();
    checks++;
    if (cmd_valid !== 1'b0 || cmd_data !== 32'd0) begin
      $display("FAIL pop_to_empty: got valid=%b data=%h want 0/0", cmd_valid, cmd_data);
      errors++;
    end
  endtask

  task automatic test_filter();
    rf_write(5'd28, 32'h11, 1'b0, 1'b0);
    rf_write(5'd30, 32'h22, 1'b0, 1'b0);
    rf_write(5'd0,  32'h33, 1'b0, 1'b0);
    rf_write(5'd29, 32'h44, 1'b1, 1'b0);
    checks++;
    if (cmd_count !== 3'd0 || overflow !== 1'b0 || cmd_valid !== 1'b0) begin
      $display("FAIL filter: got count=%0d ovf=%b valid=%b want 0/0/0", cmd_count, overflow, cmd_valid);
      errors++;
    end
    pop_one();
    checks++;
    if (cmd_count !== 3'd0) begin
      $display("FAIL ready_when_empty: got count=%0d want 0", cmd_count);
      errors++;
    end
    // Push with ready high while empty: the word must still be stored.
    rf_write(5'd29, 32'h55, 1'b0, 1'b1);
    checks++;
    if (cmd_count !== 3'd1 || cmd_data !== 32'h55) begin
      $display("FAIL push_pop_empty: got count=%0d data=%h want 1/55", cmd_count, cmd_data);
      errors++;
    end
    pop_one();
  endtask

  task automatic test_back_to_back();
    rf_write(5'd29, 32'd10, 1'b0, 1'b0);
    for (int i = 11; i <= 15; i++) begin
      rf_write(5'd29, 32'(i), 1'b0, 1'b1);
      checks++;
      if (cmd_count !== 3'd1 || cmd_data !== 32'(i)) begin
        $display("FAIL back_to_back[%0d]: got count=%0d data=%0d want 1/%0d", i, cmd_count, cmd_data, i);
        errors++;
      end
    end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_vals [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    for (int i = 1; i <= 6; i++) rf_write(5'd29, 32'(i), 1'b0, 1'b0);
    checks++;
    if (cmd_count !== 3'd4 || overflow !== 1'b1 || drop_count !== 8'd2) begin
      $display("FAIL overflow: got count=%0d ovf=%b drops=%0d want 4/1/2", cmd_count, overflow, drop_count);
      errors++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_data !== exp_vals[i]) begin
        $display("FAIL overflow_drain[%0d]: got valid=%b data=%0d want 1/%0d", i, cmd_valid, cmd_data, exp_vals[i]);
        errors++;
      end
      pop_one();
    end
    checks++;
    if (cmd_valid !== 1'b0 || cmd_count !== 3'd0) begin
      $display("FAIL overflow_empty: got valid=%b count=%0d want 0/0", cmd_valid, cmd_count);
      errors++;
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_vals [4] = '{32'd2, 32'd3, 32'd4, 32'd9};
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    for (int i = 1; i <= 4; i++) rf_write(5'd29, 32'(i), 1'b0, 1'b0);
    rf_write(5'd29, 32'd9, 1'b0, 1'b1);
    checks++;
    if (cmd_count !== 3'd4 || drop_count !== 8'd0 || overflow !== 1'b0) begin
      $display("FAIL full_push_pop: got count=%0d drops=%0d ovf=%b want 4/0/0", cmd_count, drop_count, overflow);
      errors++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd_data !== exp_vals[i]) begin
        $display("FAIL full_push_pop_drain[%0d]: got %0d want %0d", i, cmd_data, exp_vals[i]);
        errors++;
      end
      pop_one();
    end
  endtask

  task automatic test_saturate_clear();
    for (int i = 1; i <= 4; i++) rf_write(5'd29, 32'(i + 100), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) rf_write(5'd29, 32'hdead, 1'b0, 1'b0);
    checks++;
    if (drop_count !== 8'd255 || overflow !== 1'b1 || cmd_count !== 3'd4 || cmd_data !== 32'd101) begin
      $display("FAIL saturate: got drops=%0d ovf=%b count=%0d head=%0d want 255/1/4/101",
               drop_count, overflow, cmd_count, cmd_data);
      errors++;
    end
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd29;
    data_writeReg    = 32'hbeef;
    clear_overflow   = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0 || cmd_count !== 3'd4) begin
      $display("FAIL clear_with_drop: got ovf=%b drops=%0d count=%0d want 0/0/4", overflow, drop_count, cmd_count);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    pop_one();
    checks++;
    if (cmd_count !== 3'd3 || cmd_data !== 32'd102) begin
      $display("FAIL pre_reset: got count=%0d data=%0d want 3/102", cmd_count, cmd_data);
      errors++;
    end
    rf_write(5'd29, 32'h1, 1'b0, 1'b0);
    rf_write(5'd29, 32'h2, 1'b0, 1'b0);
    rf_write(5'd29, 32'h3, 1'b0, 1'b0);
    rf_write(5'd29, 32'h4, 1'b0, 1'b0);
    rf_write(5'd29, 32'h5, 1'b0, 1'b0);
    reset     = 1'b1;
    cmd_ready = 1'b1;
    step();
    reset     = 1'b0;
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_data !== 32'd0 || cmd_count !== 3'd0 ||
        overflow !== 1'b0 || drop_count !== 8'd0) begin
      $display("FAIL reset_mid: got valid=%b data=%h count=%0d ovf=%b drops=%0d want all 0",
               cmd_valid, cmd_data, cmd_count, overflow, drop_count);
      errors++;
    end
    rf_write(5'd29, 32'h7, 1'b0, 1'b0);
    checks++;
    if (cmd_data !== 32'h7 || cmd_count !== 3'd1) begin
      $display("FAIL after_reset: got data=%h count=%0d want 7/1", cmd_data, cmd_count);
      errors++;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_capture_pop();
    test_filter();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_saturate_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
